// File: rtl/sdram_cmd_checker.sv
// SDRAM command-bus monitor: decodes each sampled command, follows the power-up init sequence,
// checks command spacing and reports sticky errors. Refresh watchdog built with SDRAM_CHK_REFRESH_WDT_EN.
module sdram_cmd_checker #(
    parameter logic [15:0] T_STABLE       = 16'd20000,
    parameter logic [15:0] T_RP           = 16'd3,
    parameter logic [15:0] T_RC           = 16'd7,
    parameter logic [15:0] T_MRD          = 16'd2,
    parameter logic [3:0]  INIT_REF       = 4'd2,
    parameter logic [15:0] REFRESH_PERIOD = 16'd780
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cke_i,
    input  logic        cs_n_i,
    input  logic        ras_n_i,
    input  logic        cas_n_i,
    input  logic        we_n_i,
    input  logic [11:0] addr_i,
    input  logic [1:0]  bank_i,
    output logic        init_done_o,
    output logic [11:0] mode_reg_o,
    output logic [15:0] refresh_cnt_o,
    output logic [2:0]  err_flags_o,
    output logic        err_pulse_o
);

    typedef enum logic [2:0] {
        ST_STABLE,
        ST_WAIT_PRE,
        ST_WAIT_REF,
        ST_WAIT_MRS,
        ST_READY
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stable_cnt_q, stable_cnt_d;
    logic [3:0]  init_ref_q, init_ref_d;
    logic [15:0] busy_q, busy_d;
    logic [15:0] refresh_cnt_q, refresh_cnt_d;
    logic [11:0] mode_reg_q, mode_reg_d;
    logic        init_done_q, init_done_d;
    logic [2:0]  err_flags_q, err_flags_d;
    logic        err_pulse_q, err_pulse_d;

    logic [3:0]  cmd;
    logic        is_nop, is_pre, is_ref, is_mrs;
    logic        seq_evt, tim_evt, ref_evt;
    logic        mrs_capture, mrs_init;
    logic        bank_unused;

    assign cmd         = {cs_n_i, ras_n_i, cas_n_i, we_n_i};
    assign is_nop      = cs_n_i | (cmd[2:0] == 3'b111);
    assign is_pre      = (cmd == 4'b0010);
    assign is_ref      = (cmd == 4'b0001);
    assign is_mrs      = (cmd == 4'b0000);
    assign bank_unused = ^bank_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_STABLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stable_cnt_d = stable_cnt_q;
        init_ref_d  = init_ref_q;
        seq_evt     = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (cke_i && (stable_cnt_q != T_STABLE)) begin
                    stable_cnt_d = stable_cnt_q + 16'd1;
                end
                // An early command holds the state for this cycle; the saturated count releases it next cycle.
                if (!is_nop) begin
                    seq_evt = 1'b1;
                end else if (stable_cnt_d == T_STABLE) begin
                    state_d = ST_WAIT_PRE;
                end
            end
            ST_WAIT_PRE: begin
                if (is_pre && addr_i[10]) begin
                    state_d    = ST_WAIT_REF;
                    init_ref_d = '0;
                end else if (!is_nop) begin
                    seq_evt = 1'b1;
                end
            end
            ST_WAIT_REF: begin
                if (is_ref) begin
                    init_ref_d = init_ref_q + 4'd1;
                    if (init_ref_d == INIT_REF) begin
                        state_d = ST_WAIT_MRS;
                    end
                end else if (!is_nop) begin
                    seq_evt = 1'b1;
                end
            end
            ST_WAIT_MRS: begin
                if (is_mrs) begin
                    state_d = ST_READY;
                end else if (!is_nop && !is_ref) begin
                    seq_evt = 1'b1;
                end
            end
            ST_READY: begin
                if (!cke_i) begin
                    seq_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase
    end

    always_comb begin
        mrs_capture = is_mrs && ((state_q == ST_WAIT_MRS) || (state_q == ST_READY));
        mrs_init    = is_mrs && (state_q == ST_WAIT_MRS);
        tim_evt     = !is_nop && (busy_q != '0);

        busy_d = busy_q;
        if (is_pre) begin
            busy_d = T_RP - 16'd1;
        end else if (is_ref) begin
            busy_d = T_RC - 16'd1;
        end else if (is_mrs) begin
            busy_d = T_MRD - 16'd1;
        end else if (busy_q != '0) begin
            busy_d = busy_q - 16'd1;
        end

        refresh_cnt_d = refresh_cnt_q;
        if (is_ref && (refresh_cnt_q != '1)) begin
            refresh_cnt_d = refresh_cnt_q + 16'd1;
        end

        mode_reg_d  = mrs_capture ? addr_i : mode_reg_q;
        init_done_d = init_done_q | mrs_init;
        err_flags_d = err_flags_q | {ref_evt, tim_evt, seq_evt};
        err_pulse_d = ref_evt | tim_evt | seq_evt;
    end

`ifdef SDRAM_CHK_REFRESH_WDT_EN
    logic [15:0] wdt_q, wdt_d;

    // Once past the limit the count parks, so each missed refresh reports exactly once.
    always_comb begin
        wdt_d   = wdt_q;
        ref_evt = 1'b0;
        if ((state_q != ST_READY) || is_ref) begin
            wdt_d = '0;
        end else if ((wdt_q <= REFRESH_PERIOD) && (wdt_q != '1)) begin
            wdt_d   = wdt_q + 16'd1;
            ref_evt = (wdt_d > REFRESH_PERIOD);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    assign ref_evt = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_cnt_q  <= '0;
            init_ref_q    <= '0;
            busy_q        <= '0;
            refresh_cnt_q <= '0;
            mode_reg_q    <= '0;
            init_done_q   <= 1'b0;
            err_flags_q   <= '0;
            err_pulse_q   <= 1'b0;
        end else begin
            stable_cnt_q  <= stable_cnt_d;
            init_ref_q    <= init_ref_d;
            busy_q        <= busy_d;
            refresh_cnt_q <= refresh_cnt_d;
            mode_reg_q    <= mode_reg_d;
            init_done_q   <= init_done_d;
            err_flags_q   <= err_flags_d;
            err_pulse_q   <= err_pulse_d;
        end
    end

    assign init_done_o   = init_done_q;
    assign mode_reg_o    = mode_reg_q;
    assign refresh_cnt_o = refresh_cnt_q;
    assign err_flags_o   = err_flags_q;
    assign err_pulse_o   = err_pulse_q;

endmodule
